mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single-port memory; IDLE -> ACCESS -> DONE per access.
// Define ARB_ROUND_ROBIN_EN for an alternating tie-break; otherwise the CPU wins every tie.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_wen,
  input  logic [AW-1:0]    c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_ack,
  input  logic             d_req,
  input  logic             d_wen,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             m_en,
  output logic             m_wen,
  output logic [AW-1:0]    m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_reg, state_next;
  logic             m_en_reg, m_en_next;
  logic             m_wen_reg, m_wen_next;
  logic [AW-1:0]    m_addr_reg, m_addr_next;
  logic [WIDTH-1:0] m_wdata_reg, m_wdata_next;
  logic [WIDTH-1:0] c_rdata_reg, c_rdata_next;
  logic [WIDTH-1:0] d_rdata_reg, d_rdata_next;
  logic             c_ack_reg, c_ack_next;
  logic             d_ack_reg, d_ack_next;
  logic             owner_reg, owner_next;
  // m_wen is dropped in ACCESS, so the read/write nature is kept here for DONE.
  logic             xfer_wen_reg, xfer_wen_next;
  logic             grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_reg, last_next;

  // last_reg = 1 means debug was granted last, so a tie goes to the CPU.
  assign grant_d = d_req & (~c_req | ~last_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_reg <= 1'b1;
    else        last_reg <= last_next;
  end
`else
  assign grant_d = d_req & ~c_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      m_en_reg     <= 1'b0;
      m_wen_reg    <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      c_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      c_ack_reg    <= 1'b0;
      d_ack_reg    <= 1'b0;
      owner_reg    <= 1'b0;
      xfer_wen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      m_en_reg     <= m_en_next;
      m_wen_reg    <= m_wen_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      c_rdata_reg  <= c_rdata_next;
      d_rdata_reg  <= d_rdata_next;
      c_ack_reg    <= c_ack_next;
      d_ack_reg    <= d_ack_next;
      owner_reg    <= owner_next;
      xfer_wen_reg <= xfer_wen_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    m_en_next     = 1'b0;
    m_wen_next    = m_wen_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    c_rdata_next  = c_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    c_ack_next    = 1'b0;
    d_ack_next    = 1'b0;
    owner_next    = owner_reg;
    xfer_wen_next = xfer_wen_reg;
`ifdef ARB_ROUND_ROBIN_EN
    last_next     = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (c_req || d_req) begin
          owner_next    = grant_d;
          m_en_next     = 1'b1;
          m_wen_next    = grant_d ? d_wen   : c_wen;
          m_addr_next   = grant_d ? d_addr  : c_addr;
          m_wdata_next  = grant_d ? d_wdata : c_wdata;
          xfer_wen_next = grant_d ? d_wen   : c_wen;
`ifdef ARB_ROUND_ROBIN_EN
          last_next     = grant_d;
`endif
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        m_wen_next = 1'b0;
        state_next = DONE;
      end
      DONE: begin
        // m_rdata is valid during DONE, so it is captured together with the ack.
        if (owner_reg) begin
          d_ack_next = 1'b1;
          if (!xfer_wen_reg) d_rdata_next = m_rdata;
        end else begin
          c_ack_next = 1'b1;
          if (!xfer_wen_reg) c_rdata_next = m_rdata;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_en    = m_en_reg;
  assign m_wen   = m_wen_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign c_rdata = c_rdata_reg;
  assign d_rdata = d_rdata_reg;
  assign c_ack   = c_ack_reg;
  assign d_ack   = d_ack_reg;
  assign owner   = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random request traffic against a
// transaction-level reference model and a behavioural memory on the m_* side.
module tb_mem_arbiter;
  localparam int W = 32;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         c_req = 1'b0, c_wen = 1'b0;
  logic [A-1:0] c_addr = '0;
  logic [W-1:0] c_wdata = '0;
  logic [W-1:0] c_rdata;
  logic         c_ack;
  logic         d_req = 1'b0, d_wen = 1'b0;
  logic [A-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_ack;
  logic         m_en, m_wen;
  logic [A-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         owner;

  int n_checks = 0;
  int n_fail = 0;
  int n_txn = 0;

  mem_arbiter #(.WIDTH(W), .AW(A)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hCAFEF00D;
    return {16'hA5C3, a, ~a};
  endfunction

  // Behavioural single-port memory: read data valid the cycle after m_en.
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      m_rdata <= '0;
    end else if (m_en) begin
      if (m_wen) mem[m_addr[7:0]] <= m_wdata;
      m_rdata <= mem[m_addr[7:0]];
    end
  end

  // Reference model state
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] exp_c_rdata, exp_d_rdata, exp_m_wdata;
  logic [A-1:0] exp_m_addr;
  logic         last_d;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    exp_c_rdata = '0;
    exp_d_rdata = '0;
    exp_m_addr  = '0;
    exp_m_wdata = '0;
    last_d      = 1'b1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic pick_debug(input logic cr, input logic dr);
    if (cr && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_d;
`else
      return 1'b0;
`endif
    end
    return dr;
  endfunction

  // Called just after a clock edge with the arbiter idle and requests already driven.
  task automatic step_txn();
    logic         g, ew;
    logic [A-1:0] ea;
    logic [W-1:0] ed, exp_rd;
    if (!c_req && !d_req) begin
      @(posedge clk); #1;
      check_eq("idle_m_en", m_en, 0);
      check_eq("idle_m_addr", m_addr, exp_m_addr);
      check_eq("idle_m_wdata", m_wdata, exp_m_wdata);
      check_eq("idle_acks", {c_ack, d_ack}, 0);
      $display("txn %0d: idle m_addr=%h", n_txn, m_addr);
    end else begin
      g  = pick_debug(c_req, d_req);
      ew = g ? d_wen : c_wen;
      ea = g ? d_addr : c_addr;
      ed = g ? d_wdata : c_wdata;
      @(posedge clk); #1;
      check_eq("grant_m_en", m_en, 1);
      check_eq("grant_m_wen", m_wen, ew);
      check_eq("grant_m_addr", m_addr, ea);
      check_eq("grant_m_wdata", m_wdata, ed);
      check_eq("grant_owner", owner, g);
      check_eq("grant_acks", {c_ack, d_ack}, 0);
      exp_m_addr  = ea;
      exp_m_wdata = ed;
      last_d      = g;
      // Grantee changes its inputs mid-flight; the transaction must not notice.
      if (g) begin d_addr = d_addr ^ 16'h0089; d_wdata = ~d_wdata; d_wen = ~d_wen; end
      else   begin c_addr = c_addr ^ 16'h0089; c_wdata = ~c_wdata; c_wen = ~c_wen; end
      @(posedge clk); #1;
      check_eq("access_m_en", m_en, 0);
      check_eq("access_m_wen", m_wen, 0);
      check_eq("access_m_addr", m_addr, ea);
      check_eq("access_acks", {c_ack, d_ack}, 0);
      exp_rd = ref_mem[ea[7:0]];
      if (ew) ref_mem[ea[7:0]] = ed;
      else if (g) exp_d_rdata = exp_rd;
      else exp_c_rdata = exp_rd;
      @(posedge clk); #1;
      check_eq("done_c_ack", c_ack, !g);
      check_eq("done_d_ack", d_ack, g);
      check_eq("done_c_rdata", c_rdata, exp_c_rdata);
      check_eq("done_d_rdata", d_rdata, exp_d_rdata);
      check_eq("done_m_en", m_en, 0);
      check_eq("done_m_addr", m_addr, ea);
      $display("txn %0d: grant=%s wen=%0b addr=%h wdata=%h c_rdata=%h d_rdata=%h last=%0d",
               n_txn, g ? "DBG" : "CPU", ew, ea, ed, c_rdata, d_rdata, last_d);
    end
    n_txn++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : main
    logic [3:0] seq;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_en", m_en, 0);
    check_eq("rst_m_wen", m_wen, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_m_wdata", m_wdata, 0);
    check_eq("rst_rdata", {c_rdata, d_rdata}, 0);
    check_eq("rst_acks_owner", {c_ack, d_ack, owner}, 0);
    reset = 1'b1;

    // CPU read of 0x0010, with c_addr moved to 0x0099 while in flight
    c_req = 1'b1; c_wen = 1'b0; c_addr = 16'h0010; c_wdata = 32'h0;
    step_txn();
    check_eq("cpu_read_value", c_rdata, 64'hCAFEF00D);
    c_req = 1'b0;
    step_txn();

    // Debug write then debug read-back
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678;
    step_txn();
    d_wen = 1'b0; d_addr = 16'h0020;
    step_txn();
    check_eq("dbg_readback", d_rdata, 64'h12345678);
    d_req = 1'b0;

    // Four tied transactions right after reset
    do_reset();
    seq = '0;
    c_req = 1'b1; d_req = 1'b1;
    c_addr = 16'($urandom); d_addr = 16'($urandom);
    c_wdata = $urandom; d_wdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      step_txn();
      seq = {seq[2:0], owner};
    end
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("tie_order", seq, 4'b0101);
`else
    check_eq("tie_order", seq, 4'b0000);
`endif
    c_req = 1'b0; d_req = 1'b0;
    step_txn();

    // Reset during ACCESS of a CPU read aborts it
    c_req = 1'b1; c_wen = 1'b0; c_addr = 16'h0044;
    @(posedge clk); #1;
    check_eq("abort_pre_m_en", m_en, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_m_outs", {m_en, m_wen, m_addr, m_wdata}, 0);
    check_eq("abort_rdata", {c_rdata, d_rdata}, 0);
    check_eq("abort_acks_owner", {c_ack, d_ack, owner}, 0);
    model_reset();
    @(posedge clk); #1;
    check_eq("abort_no_ack", {c_ack, d_ack}, 0);
    reset = 1'b1;
    step_txn();
    c_req = 1'b0;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      c_req = ($urandom_range(0, 9) < 6);
      d_req = ($urandom_range(0, 9) < 6);
      c_wen = 1'($urandom); d_wen = 1'($urandom);
      c_addr = 16'($urandom_range(0, 15)); d_addr = 16'($urandom_range(0, 15));
      c_wdata = $urandom; d_wdata = $urandom;
      step_txn();
    end
    c_req = 1'b0; d_req = 1'b0;
    step_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
